// File: rtl/wallace_mult_if.sv
// Handshake bundle between an operand producer and wallace_mult_pipe.
//   in_valid/in_ready   : operand handshake (in_a, in_b, in_signed[, in_tag])
//   out_valid/out_ready : product handshake (out_p[, out_tag])
// Modports: master = operand producer / product consumer, slave = multiplier.
// Optional macro WALLACE_MULT_TAG_EN adds the in_tag/out_tag pass-through.
interface wallace_mult_if #(
    parameter int unsigned WIDTH = 8
`ifdef WALLACE_MULT_TAG_EN
    ,
    parameter int unsigned TAG_W = 4
`endif
);
    localparam int unsigned OUT_W = 2 * WIDTH;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_signed;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_p;

`ifdef WALLACE_MULT_TAG_EN
    logic [TAG_W-1:0] in_tag;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
        input  in_ready, out_valid, out_p, out_tag
    );
    modport slave (
        input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
        output in_ready, out_valid, out_p, out_tag
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_signed, out_ready,
        input  in_ready, out_valid, out_p
    );
    modport slave (
        input  in_valid, in_a, in_b, in_signed, out_ready,
        output in_ready, out_valid, out_p
    );
`endif
endinterface

// File: rtl/wallace_mult_pipe.sv
// Three-stage pipelined WIDTH x WIDTH Wallace-tree multiplier with a
// per-transaction signed/unsigned mode and valid/ready on both sides.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, flushes every stage
//   bus : wallace_mult_if.slave (operands in, product out)
// S1: Baugh-Wooley partial products + one 3:2 layer; S2: reduce to sum/carry;
// S3: carry-propagate add. The stall is global: every stage loads only when
// the output register is empty or being drained.
// Optional macro WALLACE_MULT_TAG_EN carries a TAG_W tag alongside the data.
module wallace_mult_pipe #(
    parameter int unsigned WIDTH = 8
`ifdef WALLACE_MULT_TAG_EN
    ,
    parameter int unsigned TAG_W = 4
`endif
) (
    input  logic          clk,
    input  logic          rst,
    wallace_mult_if.slave bus
);
    localparam int unsigned OUT_W = 2 * WIDTH;
    // WIDTH partial-product rows plus one row holding the sign-correction constants
    localparam int unsigned ROWS  = WIDTH + 1;
    // Rows left after the single 3:2 layer done in S1
    localparam int unsigned ROWS1 = ROWS - ROWS / 3;

    typedef logic [OUT_W-1:0]           row_t;
    typedef logic [ROWS-1:0][OUT_W-1:0] rows_t;

    // Baugh-Wooley matrix: cross terms with exactly one MSB operand bit are
    // inverted in signed mode, and 1s are added at columns WIDTH and OUT_W-1.
    function automatic rows_t pp_rows(input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b,
                                      input logic             sgn);
        rows_t r;
        logic  bit_v;
        r = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            for (int unsigned j = 0; j < WIDTH; j++) begin
                bit_v = a[j] & b[i];
                if (sgn && ((i == WIDTH - 1) != (j == WIDTH - 1))) begin
                    bit_v = ~bit_v;
                end
                r[i][i + j] = bit_v;
            end
        end
        r[WIDTH][WIDTH]     = sgn;
        r[WIDTH][OUT_W - 1] = sgn;
        return r;
    endfunction

    // One Wallace layer over the first n rows: each group of three rows goes
    // through a row of full adders (bit positions holding constant zeros
    // collapse to half adders); leftover rows pass straight through.
    function automatic rows_t csa_layer(input rows_t in_r, input int unsigned n);
        rows_t       out_r;
        row_t        x;
        row_t        y;
        row_t        z;
        int unsigned m;
        out_r = '0;
        m     = 0;
        for (int unsigned g = 0; g < ROWS / 3; g++) begin
            if (3 * g + 2 < n) begin
                x            = in_r[3 * g];
                y            = in_r[3 * g + 1];
                z            = in_r[3 * g + 2];
                out_r[m]     = x ^ y ^ z;
                out_r[m + 1] = ((x & y) | (x & z) | (y & z)) << 1;
                m            = m + 2;
            end
        end
        for (int unsigned k = 0; k < ROWS; k++) begin
            if (k >= 3 * (n / 3) && k < n) begin
                out_r[m] = in_r[k];
                m        = m + 1;
            end
        end
        return out_r;
    endfunction

    // Repeated layers until two rows remain; returns {carry, sum}.
    function automatic logic [2*OUT_W-1:0] reduce_two(input rows_t in_r,
                                                      input int unsigned n);
        rows_t       r;
        int unsigned cnt;
        r   = in_r;
        cnt = n;
        for (int unsigned l = 0; l < ROWS; l++) begin
            if (cnt > 2) begin
                r   = csa_layer(r, cnt);
                cnt = cnt - cnt / 3;
            end
        end
        return {r[1], r[0]};
    endfunction

    // Rows above ROWS1 in the S1 register are always zero and trim away.
    logic  s1_valid_q;
    rows_t s1_rows_q;
    rows_t s1_rows_d;
    logic  s2_valid_q;
    row_t  s2_sum_q;
    row_t  s2_carry_q;
    row_t  s2_sum_d;
    row_t  s2_carry_d;
    logic  out_valid_q;
    row_t  out_p_q;
    row_t  out_p_d;
    logic  adv;

    // Global pipeline enable
    assign adv = !out_valid_q || bus.out_ready;

    // Stage logic feeding each register bank
    always_comb begin
        s1_rows_d              = csa_layer(pp_rows(bus.in_a, bus.in_b, bus.in_signed), ROWS);
        {s2_carry_d, s2_sum_d} = reduce_two(s1_rows_q, ROWS1);
        out_p_d                = s2_sum_q + s2_carry_q;
    end

    // Data and valid pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_rows_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_sum_q    <= '0;
            s2_carry_q  <= '0;
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
        end else if (adv) begin
            s1_valid_q  <= bus.in_valid;
            s1_rows_q   <= s1_rows_d;
            s2_valid_q  <= s1_valid_q;
            s2_sum_q    <= s2_sum_d;
            s2_carry_q  <= s2_carry_d;
            out_valid_q <= s2_valid_q;
            out_p_q     <= out_p_d;
        end
    end

`ifdef WALLACE_MULT_TAG_EN
    logic [TAG_W-1:0] s1_tag_q;
    logic [TAG_W-1:0] s2_tag_q;
    logic [TAG_W-1:0] out_tag_q;

    // Tag rides alongside the data through every stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_tag_q  <= '0;
            s2_tag_q  <= '0;
            out_tag_q <= '0;
        end else if (adv) begin
            s1_tag_q  <= bus.in_tag;
            s2_tag_q  <= s1_tag_q;
            out_tag_q <= s2_tag_q;
        end
    end

    assign bus.out_tag = out_tag_q;
`endif

    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.out_p     = out_p_q;

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Testbench for wallace_mult_pipe at WIDTH=8: directed vectors with literal
// expectations plus a queue-based arithmetic model checked on every cycle
// the product output is valid.
`timescale 1ns/1ps
module tb_wallace_mult_pipe;
    localparam int unsigned W  = 8;
    localparam int unsigned OW = 2 * W;
    localparam int unsigned TW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

`ifdef WALLACE_MULT_TAG_EN
    wallace_mult_if #(.WIDTH(W), .TAG_W(TW)) bus ();
    wallace_mult_pipe #(.WIDTH(W), .TAG_W(TW)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
    wallace_mult_if #(.WIDTH(W)) bus ();
    wallace_mult_pipe #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    int unsigned checks   = 0;
    int unsigned failures = 0;

    typedef struct {
        logic [OW-1:0] p;
        logic [TW-1:0] t;
        int unsigned   cyc;
        int unsigned   stalls;
    } exp_t;

    exp_t          exp_q[$];
    int unsigned   cyc       = 0;
    int unsigned   stall_cnt = 0;
    int unsigned   fires     = 0;
    logic [TW-1:0] cur_tag   = '0;

    logic [W-1:0] corners [5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
    logic [W-1:0] bp_a    [6] = '{8'd3, 8'h80, 8'd200, 8'hF6, 8'd17, 8'h7F};
    logic [W-1:0] bp_b    [6] = '{8'd5, 8'h01, 8'd200, 8'h0A, 8'hFF, 8'h80};
    logic         bp_s    [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Exact product modulo 2^OW from plain integer arithmetic
    function automatic logic [OW-1:0] model_mul(input logic [W-1:0] a,
                                                input logic [W-1:0] b,
                                                input logic         s);
        longint x;
        longint y;
        x = longint'(a);
        y = longint'(b);
        if (s && a[W-1]) x = x - (longint'(1) << W);
        if (s && b[W-1]) y = y - (longint'(1) << W);
        return OW'(x * y);
    endfunction

    // Drive one cycle of stimulus after the edge, return at the following negedge
    task automatic tick(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [TW-1:0] t, input logic ordy);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_signed = s;
        bus.out_ready = ordy;
        cur_tag       = t;
`ifdef WALLACE_MULT_TAG_EN
        bus.in_tag    = t;
`endif
        @(negedge clk);
    endtask

    task automatic set_rst(input logic r);
        @(posedge clk);
        #1;
        rst           = r;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic expect_out(input string name, input logic v, input logic [OW-1:0] p);
        check({name, "_valid"}, bus.out_valid, v);
        if (v) check({name, "_p"}, bus.out_p, p);
    endtask

    // Scoreboard: transfers are decided by the values stable at this negedge
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", bus.out_valid, 1'b0);
                end else begin
                    check("model_out_p", bus.out_p, exp_q[0].p);
                    if (bus.out_ready) begin
                        check("latency", cyc - exp_q[0].cyc - (stall_cnt - exp_q[0].stalls), 3);
`ifdef WALLACE_MULT_TAG_EN
                        check("out_tag", bus.out_tag, exp_q[0].t);
`endif
                        void'(exp_q.pop_front());
                        fires++;
                    end
                end
                if (!bus.out_ready) stall_cnt++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back('{p: model_mul(bus.in_a, bus.in_b, bus.in_signed),
                                  t: cur_tag, cyc: cyc, stalls: stall_cnt});
            end
        end
    end

    initial begin
        int unsigned   k;
        int unsigned   i;
        int unsigned   fires0;
        logic          ordy;
        logic [W-1:0]  ra;
        logic [W-1:0]  rb;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_signed = 1'b0;
        bus.out_ready = 1'b1;
`ifdef WALLACE_MULT_TAG_EN
        bus.in_tag    = '0;
`endif

        // Pin the model against hand-computed products
        check("model_u_ff_ff", model_mul(8'hFF, 8'hFF, 1'b0), 16'hFE01);
        check("model_s_80_80", model_mul(8'h80, 8'h80, 1'b1), 16'h4000);
        check("model_s_ff_05", model_mul(8'hFF, 8'h05, 1'b1), 16'hFFFB);

        // Reset with random inputs
        for (int n = 0; n < 4; n++) begin
            tick(1'($urandom), W'($urandom), W'($urandom), 1'($urandom), TW'($urandom), 1'($urandom));
            check("rst_out_valid", bus.out_valid, 1'b0);
            check("rst_out_p", bus.out_p, '0);
        end
        set_rst(1'b0);
        check("post_rst_out_valid", bus.out_valid, 1'b0);
        check("post_rst_out_p", bus.out_p, '0);
        check("post_rst_in_ready", bus.in_ready, 1'b1);

        // Back-to-back products, modes alternating
        tick(1'b1, 8'hFF, 8'hFF, 1'b0, 4'h1, 1'b1);
        expect_out("pipe_empty0", 1'b0, '0);
        tick(1'b1, 8'h80, 8'h80, 1'b1, 4'h2, 1'b1);
        expect_out("pipe_empty1", 1'b0, '0);
        tick(1'b1, 8'h00, 8'hAD, 1'b0, 4'h3, 1'b1);
        expect_out("pipe_empty2", 1'b0, '0);
        tick(1'b1, 8'hFF, 8'h05, 1'b1, 4'h4, 1'b1);
        expect_out("u_ff_ff", 1'b1, 16'hFE01);
        tick(1'b0, '0, '0, 1'b0, '0, 1'b1);
        expect_out("s_80_80", 1'b1, 16'h4000);
        tick(1'b0, '0, '0, 1'b0, '0, 1'b1);
        expect_out("u_00_ad", 1'b1, 16'h0000);
        tick(1'b0, '0, '0, 1'b0, '0, 1'b1);
        expect_out("s_ff_05", 1'b1, 16'hFFFB);
        tick(1'b0, '0, '0, 1'b0, '0, 1'b1);
        expect_out("drained", 1'b0, '0);

        // Backpressure: six streamed ops, consumer stalls cycles 4..7
        fires0 = fires;
        k = 0;
        for (i = 0; i < 24; i++) begin
            ordy = !(i >= 4 && i <= 7);
            if (k < 6) tick(1'b1, bp_a[k], bp_b[k], bp_s[k], TW'(k + 5), ordy);
            else       tick(1'b0, '0, '0, 1'b0, '0, ordy);
            if (i >= 4 && i <= 7) check("bp_in_ready_low", bus.in_ready, 1'b0);
            if (i == 8)           check("bp_in_ready_high", bus.in_ready, 1'b1);
            if (k < 6 && bus.in_ready) k++;
        end
        check("bp_results", fires - fires0, 6);
        check("bp_queue_empty", exp_q.size(), 0);

        // Reset with two ops in flight
        tick(1'b1, 8'd9, 8'd9, 1'b0, 4'h9, 1'b1);
        tick(1'b1, 8'hF0, 8'd3, 1'b1, 4'hA, 1'b1);
        set_rst(1'b1);
        set_rst(1'b1);
        set_rst(1'b0);
        for (int n = 0; n < 6; n++) begin
            tick(1'b0, '0, '0, 1'b0, '0, 1'b1);
            check("midrst_no_valid", bus.out_valid, 1'b0);
        end
        tick(1'b1, 8'd12, 8'd11, 1'b0, 4'hC, 1'b1);
        expect_out("midrst_new0", 1'b0, '0);
        tick(1'b0, '0, '0, 1'b0, '0, 1'b1);
        expect_out("midrst_new1", 1'b0, '0);
        tick(1'b0, '0, '0, 1'b0, '0, 1'b1);
        expect_out("midrst_new2", 1'b0, '0);
        tick(1'b0, '0, '0, 1'b0, '0, 1'b1);
        expect_out("midrst_new3", 1'b1, 16'h0084);

        // Random traffic with random backpressure and corner operands
        for (int n = 0; n < 2500; n++) begin
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
            tick(1'($urandom_range(0, 3) != 0), ra, rb, 1'($urandom), TW'($urandom),
                 1'($urandom_range(0, 9) < 7));
        end
        for (int n = 0; n < 10; n++) tick(1'b0, '0, '0, 1'b0, '0, 1'b1);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_out_valid", bus.out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wallace_mult_pipe.md
Name: wallace_mult_pipe

Overview:
- Parametrised, pipelined Wallace-tree multiplier. It generalises the team's fixed 4x4 combinational Wallace multiplier to WIDTH x WIDTH operands.
- Adds per-transaction signed/unsigned mode, a 3-stage register pipeline and valid/ready handshakes on both sides.
- Sits between operand-producing datapath logic and any consumer that may apply backpressure.

Parameters:
- WIDTH, 8, operand width in bits; legal range 4..32.
- OUT_W, 2*WIDTH, product width; derived, do not override.
- TAG_W, 4, width of the pass-through tag. Used only when WALLACE_MULT_TAG_EN is defined.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands on in_a/in_b/in_signed are valid.
- in_ready  out  1  block accepts the input this cycle.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- in_tag  in  TAG_W  transaction tag; present only with WALLACE_MULT_TAG_EN.
- out_valid  out  1  out_p holds a valid product.
- out_ready  in  1  consumer accepts out_p this cycle.
- out_p  out  OUT_W  product.
- out_tag  out  TAG_W  tag of the product on out_p; present only with WALLACE_MULT_TAG_EN.

Behaviour:
- Reset (asynchronous, active-high): all stage valid bits clear; out_valid=0; out_p=0; out_tag=0; all internal pipeline registers clear. Reset mid-operation discards every in-flight transaction; no partial result ever appears after reset releases.
- Pipeline enable: adv = !out_valid || out_ready. All stage registers load only when adv=1. in_ready = adv, combinationally.
- An input is accepted when in_valid && in_ready.
- Stage S1: generate partial products and apply Baugh-Wooley sign correction when in_signed=1. This means inverting the MSB-row/column cross terms and adding constant 1s at columns WIDTH and 2*WIDTH-1. Reduce with one layer of full/half adders, then register.
- Stage S2: complete the Wallace reduction to two rows (sum, carry) using full/half adders only, then register.
- Stage S3: final carry-propagate add into out_p, then register; out_valid is set.
- Latency: exactly 3 cycles from acceptance to out_valid=1 when not stalled. Throughput: 1 product per cycle.
- Stall: while out_valid=1 && out_ready=0, all stages hold their values and out_p/out_tag stay stable. Bubbles are not collapsed; the stall is global.
- Bubbles: when a stage carries no valid data, its data registers may update, but its valid bit is 0. out_p is don't-care while out_valid=0 after the first transfer; it is 0 only after reset.
- Arithmetic: the result is exact modulo 2^OUT_W. Unsigned -> a*b. Signed -> a*b in two's complement over OUT_W bits. No overflow is possible.
- in_signed is captured with the operands and travels with them. Mixed modes in consecutive cycles are legal.
- Simultaneous events: an output transfer and an input acceptance in the same cycle are legal, and the pipeline shifts by one.

Optional Feature:
- Macro: WALLACE_MULT_TAG_EN.
- When defined: in_tag/out_tag ports exist. The tag is registered alongside the data in every stage and emerges on out_tag aligned with its product.
- When undefined: the tag ports and tag registers are absent. Behaviour is otherwise identical.

Test Plan:
- Reset value: assert rst with random inputs -> out_valid=0, out_p=0, in_ready=1 after release.
- Unsigned, WIDTH=8: a=255, b=255, signed=0, out_ready=1 -> after 3 cycles out_valid=1, out_p=16'hFE01. Also check a=0, b=173 -> 0.
- Signed, WIDTH=8: a=8'h80 (-128), b=8'h80 -> out_p=16'h4000. Then a=8'hFF (-1), b=8'h05 -> 16'hFFFB on the next consecutive cycle, with modes alternating.
- Backpressure: stream 6 back-to-back ops while holding out_ready=0 for cycles 4-7 -> in_ready=0 during the stall, out_p held stable, all 6 results emitted in order with none lost or duplicated.
- Reset mid-flight: accept 2 ops, assert rst in cycle 2 -> no out_valid after release until a new op is accepted, which then completes in 3 cycles.
- Random exhaustive sweep at WIDTH=4 (all 256 pairs, both modes) and 10k random pairs at WIDTH=16 and 32 against a behavioural model. With WALLACE_MULT_TAG_EN, out_tag must equal the tag sent with each operand pair.
